// File: rtl/pcm_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcm_uart_tx_pkg
// Brief    : Sequencer/framer state codes, byte-order lanes and frame length.
//            Optional macro: PCM_UART_TX_PARITY_EN (adds an even-parity bit).
// Revision : 1.0 - initial release
// ============================================================================
package pcm_uart_tx_pkg;

  localparam logic [1:0] SEQ_IDLE = 2'd0;
  localparam logic [1:0] SEQ_LOAD = 2'd1;
  localparam logic [1:0] SEQ_SEND = 2'd2;

  localparam logic [2:0] BIT_IDLE   = 3'd0;
  localparam logic [2:0] BIT_START  = 3'd1;
  localparam logic [2:0] BIT_DATA   = 3'd2;
  localparam logic [2:0] BIT_PARITY = 3'd3;
  localparam logic [2:0] BIT_STOP   = 3'd4;

  // Lane n of the frame word is word[8n+7:8n]; wire order is L lo, L hi, R lo, R hi
  localparam logic [1:0] BYTE0_LO_L = 2'd2;
  localparam logic [1:0] BYTE1_HI_L = 2'd3;
  localparam logic [1:0] BYTE2_LO_R = 2'd0;
  localparam logic [1:0] BYTE3_HI_R = 2'd1;

`ifdef PCM_UART_TX_PARITY_EN
  localparam int SYMBOLS_PER_BYTE = 11;
`else
  localparam int SYMBOLS_PER_BYTE = 10;
`endif

  function automatic int unsigned frame_cycles(input int unsigned div);
    return 4 * (SYMBOLS_PER_BYTE * div + 1) + 1;
  endfunction

  function automatic logic [1:0] byte_lane(input logic [1:0] byte_idx);
    case (byte_idx)
      2'd0:    return BYTE0_LO_L;
      2'd1:    return BYTE1_HI_L;
      2'd2:    return BYTE2_LO_R;
      default: return BYTE3_HI_R;
    endcase
  endfunction

  function automatic logic [7:0] select_byte(input logic [31:0] word,
                                             input logic [1:0]  byte_idx);
    logic [1:0] lane;
    lane = byte_lane(byte_idx);
    return word[8*lane +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcm_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : pcm_uart_tx_if
// Brief    : Capture-side sample bus, host flow control and UART/status lines.
// Revision : 1.0 - initial release
// ============================================================================
interface pcm_uart_tx_if #(
  parameter int BITS  = 32,
  parameter int DEPTH = 16
);
  logic                     sample_valid;
  logic [BITS-1:0]          sample_in;
  logic                     host_ready;
  logic                     tx;
  logic                     busy;
  logic                     fifo_empty;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   fill;

  modport master (
    output sample_valid, sample_in, host_ready,
    input  tx, busy, fifo_empty, overflow, fill
  );

  modport slave (
    input  sample_valid, sample_in, host_ready,
    output tx, busy, fifo_empty, overflow, fill
  );
endinterface
`default_nettype wire

// File: rtl/pcm_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module   : pcm_uart_tx_byte
// Brief    : Single-byte UART framer (start, 8 data LSB first, stop) with a
//            start/busy/done handshake. PCM_UART_TX_PARITY_EN adds even parity.
// Revision : 1.0 - initial release
// ============================================================================
module pcm_uart_tx_byte
  import pcm_uart_tx_pkg::*;
#(
  parameter int DIV = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       start,
  input  wire logic [7:0] data,
  output logic            tx,
  output logic            busy,
  output logic            done
);
  localparam int                  c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(DIV - 1);

  logic [2:0]         r_state;
  logic [c_cnt_w-1:0] r_baud;
  logic [2:0]         r_bit;
  logic [7:0]         r_shreg;
  logic               r_tx;
  logic               w_line;
  logic               w_bit_end;
`ifdef PCM_UART_TX_PARITY_EN
  logic               r_parity;
`endif

  assign w_bit_end = (r_baud == c_last);

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      BIT_START:  w_line = 1'b0;
      BIT_DATA:   w_line = r_shreg[0];
`ifdef PCM_UART_TX_PARITY_EN
      BIT_PARITY: w_line = r_parity;
`endif
      default:    w_line = 1'b1;
    endcase
  end

  // The line is re-timed through r_tx so the pin is glitch-free and idles high on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BIT_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
`ifdef PCM_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_tx <= w_line;
      case (r_state)
        BIT_IDLE: begin
          if (start) begin
            r_shreg <= data;
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= BIT_START;
`ifdef PCM_UART_TX_PARITY_EN
            r_parity <= ^data;
`endif
          end
        end
        BIT_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= BIT_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        BIT_DATA: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_shreg <= {1'b0, r_shreg[7:1]};
            if (r_bit == 3'd7) begin
`ifdef PCM_UART_TX_PARITY_EN
              r_state <= BIT_PARITY;
`else
              r_state <= BIT_STOP;
`endif
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef PCM_UART_TX_PARITY_EN
        BIT_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= BIT_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        BIT_STOP: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= BIT_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= BIT_IDLE;
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = (r_state != BIT_IDLE);
  assign done = (r_state == BIT_STOP) && w_bit_end;

endmodule
`default_nettype wire

// File: rtl/pcm_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : pcm_uart_tx
// Brief    : Stereo PCM frame FIFO + host flow control + 4-byte UART sequencer.
//            Optional macro: PCM_UART_TX_PARITY_EN (even parity per byte).
// Revision : 1.0 - initial release
// ============================================================================
module pcm_uart_tx
  import pcm_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUDRATE = 3_000_000,
  parameter int BITS     = 32,
  parameter int DEPTH    = 16
) (
  input  wire logic    clk,
  input  wire logic    reset,
  pcm_uart_tx_if.slave bus
);
  localparam int              c_div  = CLK_FREQ / BAUDRATE;
  localparam int              c_aw   = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_full = (c_aw + 1)'(DEPTH);

  logic [BITS-1:0] r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            r_overflow;
  logic            r_rdy_meta;
  logic            r_rdy_s;
  logic [1:0]      r_state;
  logic [1:0]      r_byte_idx;
  logic [BITS-1:0] r_word;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_byte_start;
  logic            w_byte_busy;
  logic            w_byte_done;
  logic            w_tx;
  logic [7:0]      w_byte;

  assign w_full  = (r_count == c_full);
  assign w_empty = (r_count == '0);
  // A push against a full FIFO is dropped even if a pop happens that same cycle.
  assign w_push  = bus.sample_valid && !w_full;
  assign w_pop   = (r_state == SEQ_IDLE) && !w_empty && r_rdy_s;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.sample_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (bus.sample_valid && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdy_meta <= 1'b0;
      r_rdy_s    <= 1'b0;
    end else begin
      r_rdy_meta <= bus.host_ready;
      r_rdy_s    <= r_rdy_meta;
    end
  end

  // Flow control is sampled only when a whole frame is popped; its four bytes always complete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= SEQ_IDLE;
      r_byte_idx <= '0;
      r_word     <= '0;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (w_pop) begin
            r_word     <= r_mem[r_rd_ptr];
            r_byte_idx <= '0;
            r_state    <= SEQ_LOAD;
          end
        end
        SEQ_LOAD: begin
          if (!w_byte_busy) begin
            r_state <= SEQ_SEND;
          end
        end
        SEQ_SEND: begin
          if (w_byte_done) begin
            if (r_byte_idx == 2'd3) begin
              r_state <= SEQ_IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_state    <= SEQ_LOAD;
            end
          end
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

  assign w_byte_start = (r_state == SEQ_LOAD) && !w_byte_busy;
  assign w_byte       = select_byte(r_word, r_byte_idx);

  pcm_uart_tx_byte #(
    .DIV (c_div)
  ) u_byte (
    .clk   (clk),
    .reset (reset),
    .start (w_byte_start),
    .data  (w_byte),
    .tx    (w_tx),
    .busy  (w_byte_busy),
    .done  (w_byte_done)
  );

  assign bus.tx         = w_tx;
  assign bus.busy       = (r_state != SEQ_IDLE) || w_pop;
  assign bus.fifo_empty = w_empty;
  assign bus.overflow   = r_overflow;
  assign bus.fill       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pcm_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcm_uart_tx
// Brief    : Randomised bench for pcm_uart_tx: line decoder + sample scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcm_uart_tx;
  localparam int CLK_FREQ = 12_000_000;
  localparam int BAUDRATE = 3_000_000;
  localparam int DEPTH    = 16;
  localparam int DIV      = CLK_FREQ / BAUDRATE;
`ifdef PCM_UART_TX_PARITY_EN
  localparam int SYMS = 11;
`else
  localparam int SYMS = 10;
`endif
  localparam int FRAME = 4 * (SYMS * DIV + 1) + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pcm_uart_tx_if #(.BITS(32), .DEPTH(DEPTH)) bus ();

  pcm_uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUDRATE (BAUDRATE),
    .BITS     (32),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  rx_q[$];
  logic        rxp_q[$];
  logic [31:0] exp_q[$];
  int          m_fill = 0;
  logic        m_ovf  = 1'b0;
  int          busy_cnt  = 0;
  int          busy_last = 0;
  int          bad, lat, t;
  logic [31:0] v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Serial decoder: samples each symbol mid-bit, starting from the first low on the line.
  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!reset && bus.tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = bus.tx;
        end
`ifdef PCM_UART_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        rxp_q.push_back(bus.tx);
`endif
        repeat (DIV) @(negedge clk);
        chk("stop_bit", {31'd0, bus.tx}, 32'd1);
        rx_q.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.busy === 1'b1) begin
      busy_cnt++;
    end else if (busy_cnt != 0) begin
      busy_last = busy_cnt;
      busy_cnt  = 0;
    end
  end

  task automatic push(input logic [31:0] val);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_in    = val;
    if (m_fill < DEPTH) begin
      m_fill++;
      exp_q.push_back(val);
    end else begin
      m_ovf = 1'b1;
    end
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  // Waits for every accepted sample to appear on the line, then checks byte order (and parity).
  task automatic drain(input string tag);
    int          tt;
    logic [31:0] s;
    logic [7:0]  want [4];
    logic [7:0]  got;
    tt = 0;
    while (!(rx_q.size() >= 4 * exp_q.size() && bus.busy === 1'b0 && bus.fifo_empty === 1'b1)
           && tt < 20000) begin
      @(negedge clk);
      tt++;
    end
    chk({tag, "_timeout"}, {31'd0, tt < 20000}, 32'd1);
    repeat (2) @(negedge clk);
    foreach (exp_q[k]) begin
      s = exp_q[k];
      want[0] = s[23:16];
      want[1] = s[31:24];
      want[2] = s[7:0];
      want[3] = s[15:8];
      for (int j = 0; j < 4; j++) begin
        got = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
        chk({tag, "_byte"}, {24'd0, got}, {24'd0, want[j]});
`ifdef PCM_UART_TX_PARITY_EN
        chk({tag, "_parity"}, {31'd0, (rxp_q.size() != 0) ? rxp_q.pop_front() : 1'bx},
            {31'd0, ^want[j]});
`endif
      end
    end
    chk({tag, "_extra_bytes"}, rx_q.size(), 0);
    exp_q.delete();
    rx_q.delete();
    rxp_q.delete();
    m_fill = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, want completion");
    $fatal(1);
  end

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.host_ready   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx",    {31'd0, bus.tx},         32'd1);
    chk("rst_busy",  {31'd0, bus.busy},       32'd0);
    chk("rst_empty", {31'd0, bus.fifo_empty}, 32'd1);
    chk("rst_ovf",   {31'd0, bus.overflow},   32'd0);
    chk("rst_fill",  {27'd0, bus.fill},       32'd0);
    reset = 1'b0;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fill !== '0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Known frame: latency to start bit and total busy length
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_in    = 32'h1234ABCD;
    exp_q.push_back(32'h1234ABCD);
    m_fill++;
    @(posedge clk);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    lat = 0;
    while (bus.tx !== 1'b0 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 3);
    drain("s2");
    chk("s2_busy_len", busy_last, FRAME);

    // Held frames released back-to-back
    bus.host_ready = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) push($urandom);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) bad++;
    end
    chk("s3_held_tx", bad, 0);
    chk("s3_fill", {27'd0, bus.fill}, m_fill);
    bus.host_ready = 1'b1;
    drain("s3");
    chk("s3_busy_len", busy_last, 3 * FRAME);

    // Overflow: only the first DEPTH samples survive
    bus.host_ready = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < DEPTH + 2; i++) push($urandom);
    repeat (5) @(negedge clk);
    chk("s4_fill", {27'd0, bus.fill}, m_fill);
    chk("s4_ovf", {31'd0, bus.overflow}, {31'd0, m_ovf});
    bus.host_ready = 1'b1;
    drain("s4");
    chk("s4_ovf_sticky", {31'd0, bus.overflow}, 32'd1);

    // Flow control dropped mid-frame: frame completes, next one is withheld
    push($urandom);
    push($urandom);
    t = 0;
    while (rx_q.size() < 1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("s5_first_byte", {31'd0, t < 2000}, 32'd1);
    repeat (2 * DIV) @(negedge clk);
    bus.host_ready = 1'b0;
    t = 0;
    while (rx_q.size() < 4 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (20) @(negedge clk);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    chk("s5_withheld", bad, 0);
    chk("s5_rx_bytes", rx_q.size(), 4);
    chk("s5_fill", {27'd0, bus.fill}, 32'd1);
    bus.host_ready = 1'b1;
    drain("s5");

    // Reset in the middle of data bit 5 (forced low so the async return is visible)
    v = $urandom & ~32'h0020_0000;
    push(v);
    t = 0;
    while (bus.tx !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("s6_start_seen", {31'd0, t < 100}, 32'd1);
    repeat (DIV + 5 * DIV + DIV / 2) @(negedge clk);
    chk("s6_pre_rst_tx", {31'd0, bus.tx}, 32'd0);
    reset = 1'b1;
    #1;
    chk("s6_rst_tx",    {31'd0, bus.tx},         32'd1);
    chk("s6_rst_busy",  {31'd0, bus.busy},       32'd0);
    chk("s6_rst_empty", {31'd0, bus.fifo_empty}, 32'd1);
    chk("s6_rst_ovf",   {31'd0, bus.overflow},   32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    rx_q.delete();
    rxp_q.delete();
    exp_q.delete();
    m_fill = 0;
    m_ovf  = 1'b0;
    push($urandom);
    drain("s6");

    // Random samples at random spacing
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 200)) @(negedge clk);
      push($urandom);
    end
    drain("s7");
    chk("end_ovf", {31'd0, bus.overflow}, {31'd0, m_ovf});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
